// File: rtl/wam_scr_bcd_if.sv
// Game-side bundle of the score counter: hole/miss inputs in, BCD score, high score and flags out.
interface wam_scr_bcd_if #(
    parameter int NHOLE = 8,
    parameter int NDIG  = 3
) ();
    logic                  new_game;
    logic                  en;
    logic [NHOLE-1:0]      hit;
    logic                  miss;
    logic [4*NDIG-1:0]     num;
    logic [4*NDIG-1:0]     hi_num;
    logic                  lvl_up;
    logic                  sat;

    modport master (
        output new_game, en, hit, miss,
        input  num, hi_num, lvl_up, sat
    );

    modport slave (
        input  new_game, en, hit, miss,
        output num, hi_num, lvl_up, sat
    );
endinterface

// File: rtl/wam_scr_bcd.sv
// Whack-a-mole BCD score counter: edge-detected multi-hit add, miss penalty,
// two-sided saturation, level-up pulse and high-score tracking.
module wam_scr_bcd #(
    parameter int NHOLE = 8,
    parameter int NDIG  = 3,
    parameter int PEN   = 1
) (
    input  logic         clk,
    input  logic         clr,
    wam_scr_bcd_if.slave bus
);
    localparam int                W     = 4 * NDIG;
    localparam logic [W-1:0]      MAX   = {NDIG{4'h9}};
    localparam logic [3:0]        PEN_L = 4'(PEN);

    logic [NHOLE-1:0] r_hit_q;
    logic             r_miss_q;
    logic [W-1:0]     r_num;
    logic [W-1:0]     r_hi;
    logic             r_lvl;
    logic             r_sat;

    logic [NHOLE-1:0] w_rise;
    logic             w_mrise;
    logic [3:0]       w_add;
    logic [3:0]       w_sub;
    logic             w_up;
    logic [3:0]       w_mag;
    logic [W-1:0]     w_sum;
    logic             w_ovf;
    logic             w_unf;
    logic [W-1:0]     w_next;
    logic             w_lvl;
    logic             w_hi_upd;

    assign w_rise  = bus.hit & ~r_hit_q;
    assign w_mrise = bus.miss & ~r_miss_q;

    // NOTE: every variable written in an always_comb gets a value before any
    // branch or loop touches it, so no path can leave it holding state (no latch).
    always_comb begin
        w_add = 4'd0;
        for (int i = 0; i < NHOLE; i++) begin
            w_add = w_add + {3'b000, w_rise[i]};
        end
    end

    // Add and penalty net out first, so the digit chain only ever sees one
    // signed delta of magnitude 0..9.
    assign w_sub = w_mrise ? PEN_L : 4'd0;
    assign w_up  = (w_add >= w_sub);
    assign w_mag = w_up ? (w_add - w_sub) : (w_sub - w_add);

    always_comb begin
        logic [4:0] w_c;
        logic [4:0] w_s;
        logic [3:0] w_dig;
        w_sum = '0;
        w_c   = {1'b0, w_mag};
        w_s   = 5'd0;
        w_dig = 4'd0;
        for (int d = 0; d < NDIG; d++) begin
            w_dig = r_num[4*d +: 4];
            if (w_up) begin
                w_s = {1'b0, w_dig} + w_c;
                if (w_s > 5'd9) begin
                    w_s = w_s - 5'd10;
                    w_c = 5'd1;
                end else begin
                    w_c = 5'd0;
                end
            end else begin
                if ({1'b0, w_dig} >= w_c) begin
                    w_s = {1'b0, w_dig} - w_c;
                    w_c = 5'd0;
                end else begin
                    w_s = {1'b0, w_dig} + 5'd10 - w_c;
                    w_c = 5'd1;
                end
            end
            w_sum[4*d +: 4] = w_s[3:0];
        end
        w_ovf = w_up & w_c[0];
        w_unf = ~w_up & w_c[0];
    end

    assign w_next   = w_ovf ? MAX : (w_unf ? '0 : w_sum);
    // Packed BCD orders the same as its value, so plain unsigned compares work.
    assign w_lvl    = (w_next[W-1:4] > r_num[W-1:4]);
    assign w_hi_upd = (w_next > r_hi);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        r_hit_q  <= bus.hit;
        r_miss_q <= bus.miss;
        if (clr) begin
            r_hit_q  <= '0;
            r_miss_q <= 1'b0;
            r_num    <= '0;
            r_hi     <= '0;
            r_lvl    <= 1'b0;
            r_sat    <= 1'b0;
        end else if (bus.new_game) begin
            r_hit_q  <= '0;
            r_miss_q <= 1'b0;
            r_num    <= '0;
            r_lvl    <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_lvl <= 1'b0;
            if (bus.en) begin
                r_num <= w_next;
                r_lvl <= w_lvl;
                if (w_ovf) begin
                    r_sat <= 1'b1;
                end
                if (w_hi_upd) begin
                    r_hi <= w_next;
                end
            end
        end
    end

    assign bus.num    = r_num;
    assign bus.hi_num = r_hi;
    assign bus.lvl_up = r_lvl;
    assign bus.sat    = r_sat;
endmodule

// File: tb/tb_wam_scr_bcd.sv
// Self-checking bench for wam_scr_bcd: directed scenarios plus random play
// against an integer score model.
module tb_wam_scr_bcd;
    localparam int NHOLE = 8;
    localparam int NDIG  = 3;
    localparam int PEN   = 1;
    localparam int W     = 4 * NDIG;
    localparam int MAXV  = 999;

    logic clk = 1'b0;
    logic clr = 1'b1;

    wam_scr_bcd_if #(.NHOLE(NHOLE), .NDIG(NDIG)) bus ();

    wam_scr_bcd #(.NHOLE(NHOLE), .NDIG(NDIG), .PEN(PEN)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    int               m_score = 0;
    int               m_hi    = 0;
    bit               m_sat   = 1'b0;
    bit               m_lvl   = 1'b0;
    logic [NHOLE-1:0] m_ph    = '0;
    bit               m_pm    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int d = 0; d < NDIG; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model(input bit c, input bit ng, input bit e,
                         input logic [NHOLE-1:0] h, input bit m);
        int n;
        int add;
        bit mr;
        if (c) begin
            m_score = 0; m_hi = 0; m_sat = 0; m_lvl = 0; m_ph = '0; m_pm = 0;
        end else if (ng) begin
            m_score = 0; m_sat = 0; m_lvl = 0; m_ph = '0; m_pm = 0;
        end else begin
            add  = $countones(h & ~m_ph);
            mr   = m & ~m_pm;
            m_ph = h;
            m_pm = m;
            m_lvl = 0;
            if (e) begin
                n = m_score + add - (mr ? PEN : 0);
                if (n > MAXV) begin
                    n = MAXV;
                    m_sat = 1;
                end
                if (n < 0) n = 0;
                m_lvl   = (n / 10) > (m_score / 10);
                m_score = n;
                if (m_score > m_hi) m_hi = m_score;
            end
        end
    endtask

    task automatic step(input bit c, input bit ng, input bit e,
                        input logic [NHOLE-1:0] h, input bit m);
        @(negedge clk);
        clr          = c;
        bus.new_game = ng;
        bus.en       = e;
        bus.hit      = h;
        bus.miss     = m;
        @(posedge clk);
        model(c, ng, e, h, m);
        #1;
        check("num",    32'(bus.num),    32'(to_bcd(m_score)));
        check("hi_num", 32'(bus.hi_num), 32'(to_bcd(m_hi)));
        check("lvl_up", 32'(bus.lvl_up), 32'(m_lvl));
        check("sat",    32'(bus.sat),    32'(m_sat));
    endtask

    task automatic play(input logic [NHOLE-1:0] h);
        step(0, 0, 1, h, 0);
    endtask

    initial begin
        bus.new_game = 1'b0;
        bus.en       = 1'b0;
        bus.hit      = '0;
        bus.miss     = 1'b0;

        step(1, 0, 1, '0, 0);
        check("rst_num", 32'(bus.num), 32'h0);
        check("rst_hi",  32'(bus.hi_num), 32'h0);
        check("rst_lvl", 32'(bus.lvl_up), 32'h0);
        check("rst_sat", 32'(bus.sat), 32'h0);

        // A level held four cycles scores once.
        play(8'h08);
        check("hold_first", 32'(bus.num), 32'h001);
        repeat (3) play(8'h08);
        play(8'h00);
        check("hold_num", 32'(bus.num), 32'h001);
        check("hold_hi",  32'(bus.hi_num), 32'h001);

        // 1 -> 8, then two simultaneous hits carry into the tens digit.
        play(8'h7F);
        play(8'h00);
        check("pre8", 32'(bus.num), 32'h008);
        play(8'h21);
        check("carry_num", 32'(bus.num), 32'h010);
        check("carry_lvl", 32'(bus.lvl_up), 32'h1);
        check("carry_hi",  32'(bus.hi_num), 32'h010);
        play(8'h00);
        check("lvl_once", 32'(bus.lvl_up), 32'h0);

        // Penalty floors at zero; penalty and hits net within a cycle.
        step(0, 1, 1, '0, 0);
        step(0, 0, 1, '0, 1);
        check("floor_num", 32'(bus.num), 32'h000);
        check("floor_sat", 32'(bus.sat), 32'h0);
        step(0, 0, 1, '0, 0);
        play(8'h1F);
        play(8'h00);
        step(0, 0, 1, 8'h03, 1);
        check("net_num", 32'(bus.num), 32'h006);
        step(0, 0, 1, '0, 0);

        // Climb to 997, then clip at the top.
        while (m_score + 8 <= 997) begin
            play(8'hFF);
            play(8'h00);
        end
        play(8'h7F);
        play(8'h00);
        check("pre997", 32'(bus.num), 32'h997);
        play(8'hFF);
        check("clip_num", 32'(bus.num), 32'h999);
        check("clip_sat", 32'(bus.sat), 32'h1);
        check("clip_lvl", 32'(bus.lvl_up), 32'h0);
        step(0, 0, 1, '0, 1);
        check("post_clip_num", 32'(bus.num), 32'h998);
        check("post_clip_sat", 32'(bus.sat), 32'h1);

        // new_game keeps the high score, clr drops it.
        step(1, 0, 1, '0, 0);
        repeat (2) begin
            play(8'hFF);
            play(8'h00);
        end
        play(8'h7F);
        play(8'h00);
        check("pre23", 32'(bus.num), 32'h023);
        step(0, 1, 1, '0, 0);
        check("ng_num", 32'(bus.num), 32'h000);
        check("ng_hi",  32'(bus.hi_num), 32'h023);
        play(8'h1F);
        play(8'h00);
        check("ng_hi_hold", 32'(bus.hi_num), 32'h023);
        step(1, 0, 1, '0, 0);
        check("clr_hi", 32'(bus.hi_num), 32'h000);

        // Edge registers track while disabled.
        step(0, 0, 0, 8'h04, 0);
        step(0, 0, 1, 8'h04, 0);
        check("en_hold", 32'(bus.num), 32'h000);
        play(8'h00);
        play(8'h04);
        check("en_rescore", 32'(bus.num), 32'h001);

        // Random play.
        for (int k = 0; k < 3000; k++) begin
            bit               c;
            bit               ng;
            bit               e;
            bit               m;
            logic [NHOLE-1:0] h;
            c  = ($urandom_range(0, 999) == 0);
            ng = ($urandom_range(0, 399) == 0);
            e  = ($urandom_range(0, 9) != 0);
            m  = ($urandom_range(0, 5) == 0);
            h  = NHOLE'($urandom);
            step(c, ng, e, h, m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/wam_scr_bcd.md
Name: wam_scr_bcd

Overview:
- Parametrised successor to the whack-a-mole score counter. Fully synchronous, single clock; no rippled carries used as clocks.
- Edge-detects per-hole hits and adds the number of new hits per cycle, so simultaneous hits each score. Subtracts a penalty on a miss, saturates at both ends, and tracks a high score.
- Drives the seven-segment score display (BCD) and the difficulty controller (lvl_up pulse).

Parameters:
- NHOLE, 8, number of hole/hit inputs; legal 1..9.
- NDIG, 3, number of BCD digits in score and high score; legal 2..6.
- PEN, 1, points subtracted per miss event; legal 0..9.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- clr  in  1  synchronous active-high reset; clears everything including hi_num.
- new_game  in  1  synchronous; clears score state only, keeps hi_num.
- en  in  1  game running; when low, hits/misses do not change the score.
- hit  in  NHOLE  per-hole hit levels; each may stay high several cycles.
- miss  in  1  miss level; rising edge = one miss event.
- num  out  4*NDIG  current score, BCD, digit 0 in [3:0].
- hi_num  out  4*NDIG  highest score reached since clr, BCD.
- lvl_up  out  1  one-cycle pulse when score/10 increases.
- sat  out  1  sticky; set when an add is clipped at the maximum.

Behaviour:
- Reset (clr=1 at edge): num=0, hi_num=0, lvl_up=0, sat=0, hit_q=0, miss_q=0. clr has priority over new_game.
- new_game=1 at edge: num=0, lvl_up=0, sat=0, hit_q=0, miss_q=0; hi_num holds.
- Edge detect: rise = hit & ~hit_q and mrise = miss & ~miss_q, both combinational from the registered previous inputs. hit_q and miss_q update every cycle regardless of en. A level held high scores exactly once.
- Cycle arithmetic with en=1:
  - add = popcount(rise), range 0..NHOLE.
  - sub = PEN if mrise, else 0.
  - next = num + add - sub, computed as a BCD digit chain (binary internally is allowed if outputs are exact BCD).
- Latency: a hit rising before edge k appears on num after edge k (1 cycle).
- Saturation:
  - next > MAX (MAX = 10^NDIG-1, all digits 9) gives num=MAX and sets sat.
  - next < 0 gives num=0; sat is unaffected.
  - add and sub in the same cycle net out before saturation is applied.
- en=0: num, sat and lvl_up hold (lvl_up=0). Edge registers still track, so a hit held across en rising does not score.
- lvl_up=1 for exactly the cycle after an edge where num/10 (tens and above) strictly increases.
  - Multi-step jumps (e.g. 9→17) give one pulse.
  - Decreases, and reaching MAX via clipping without a tens change, give no pulse.
- hi_num: at each edge, if the new num > hi_num, hi_num takes the new num in the same cycle (hi_num equals num in that cycle, no extra latency).
- Every digit of num and hi_num must always be 0..9; no invalid BCD codes are ever output.

Test Plan:
- clr, en=1, pulse hit[3] high for 4 cycles → num=0x001 after the first edge only, lvl_up never pulses, hi_num=0x001.
- num=0x008, hit[0] and hit[5] rise in the same cycle → num=0x010, lvl_up=1 for one cycle, hi_num=0x010.
- num=0x000, miss rises (PEN=1) → num stays 0x000, sat=0. Then num=0x005 with miss plus 2 hits in one cycle → num=0x006.
- Preload to 0x997 via hits; 8 hits rise simultaneously → num=0x999, sat=1, lvl_up=0. Subsequent miss → num=0x998, sat stays 1.
- Score 0x023, assert new_game → num=0x000, hi_num=0x023. Score to 0x005 → hi_num stays 0x023. Then clr → hi_num=0x000.
- en=0 with hit[2] rising, then en=1 while hit[2] is still high → num unchanged. hit[2] low then high again → +1.
